// File: rtl/fifo_rd_ser_if.sv
// Handshake bundle between the fifo read port, the serialiser and the chunk sink.
// The master modport is the serialiser's view.
interface fifo_rd_ser_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned OUT_W  = 2
) ();
   logic              fifo_empty_i;
   logic [DATA_W-1:0] fifo_data_i;
   logic              fifo_rd_o;
   logic              flush_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [OUT_W-1:0]  out_data_o;
   logic              out_last_o;
   logic              busy_o;

   modport master (
      input  fifo_empty_i, fifo_data_i, flush_i, out_ready_i,
      output fifo_rd_o, out_valid_o, out_data_o, out_last_o, busy_o
   );

   modport slave (
      output fifo_empty_i, fifo_data_i, flush_i, out_ready_i,
      input  fifo_rd_o, out_valid_o, out_data_o, out_last_o, busy_o
   );
endinterface

// File: rtl/fifo_rd_ser.sv
// Pops words from a show-ahead fifo and serialises each into DATA_W/OUT_W chunks on a
// valid/ready stream, reloading on the last accepted chunk so words run back-to-back.
module fifo_rd_ser #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned OUT_W     = 2,
   parameter bit          LSB_FIRST = 1'b1
) (
   input logic           clk,
   input logic           reset,
   fifo_rd_ser_if.master bus
);
   localparam int unsigned N     = DATA_W / OUT_W;
   localparam int unsigned CNT_W = $clog2(N) + 1;

   if (DATA_W % OUT_W != 0) begin : g_bad_width
      $error("fifo_rd_ser: DATA_W must be a multiple of OUT_W");
   end

   typedef enum logic [0:0] {StEmpty, StSend} state_e;

   state_e            r_state, w_state_d;
   logic [DATA_W-1:0] r_sh, w_sh_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic              w_valid;
   logic              w_last;
   logic              w_load;

   assign w_valid = (r_state == StSend);
   assign w_last  = w_valid && (r_cnt == '0);

   // Reload is allowed on the same edge that retires the final chunk.
   assign w_load = !bus.fifo_empty_i && !bus.flush_i &&
                   ((r_state == StEmpty) || (bus.out_ready_i && w_last));

   always_comb begin
      w_state_d = r_state;
      w_sh_d    = r_sh;
      w_cnt_d   = r_cnt;
      if (bus.flush_i) begin
         w_state_d = StEmpty;
         w_cnt_d   = '0;
      end else if (w_load) begin
         w_sh_d    = bus.fifo_data_i;
         w_cnt_d   = CNT_W'(N - 1);
         w_state_d = StSend;
      end else if (w_valid && bus.out_ready_i) begin
         if (r_cnt != '0) begin
            w_sh_d  = LSB_FIRST ? (r_sh >> OUT_W) : (r_sh << OUT_W);
            w_cnt_d = r_cnt - 1'b1;
         end else begin
            w_state_d = StEmpty;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StEmpty;
         r_sh    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_sh    <= w_sh_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Gate with reset so no pop is seen by the fifo while this stage is held.
   assign bus.fifo_rd_o   = w_load && !reset;
   assign bus.out_valid_o = w_valid;
   assign bus.busy_o      = w_valid;
   assign bus.out_last_o  = w_last;
   assign bus.out_data_o  = LSB_FIRST ? r_sh[OUT_W-1:0] : r_sh[DATA_W-1 -: OUT_W];
endmodule

// File: tb/tb_fifo_rd_ser.sv
// Directed bench for fifo_rd_ser: LSB-first, MSB-first and N=1 instances, each fed by a
// small array-based show-ahead fifo model.
module tb_fifo_rd_ser;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   fifo_rd_ser_if #(.DATA_W(8), .OUT_W(2)) if0 ();
   fifo_rd_ser_if #(.DATA_W(8), .OUT_W(2)) if1 ();
   fifo_rd_ser_if #(.DATA_W(8), .OUT_W(8)) if2 ();

   fifo_rd_ser #(.DATA_W(8), .OUT_W(2), .LSB_FIRST(1'b1)) u_dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );
   fifo_rd_ser #(.DATA_W(8), .OUT_W(2), .LSB_FIRST(1'b0)) u_dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );
   fifo_rd_ser #(.DATA_W(8), .OUT_W(8), .LSB_FIRST(1'b1)) u_dut_n1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  mem0 [16];
   logic [7:0]  mem1 [16];
   logic [7:0]  mem2 [16];
   int unsigned wp0, wp1, wp2;
   int unsigned rp0, rp1, rp2;
   int unsigned pop0;

   assign if0.fifo_empty_i = (wp0 == rp0);
   assign if1.fifo_empty_i = (wp1 == rp1);
   assign if2.fifo_empty_i = (wp2 == rp2);
   assign if0.fifo_data_i  = mem0[rp0 % 16];
   assign if1.fifo_data_i  = mem1[rp1 % 16];
   assign if2.fifo_data_i  = mem2[rp2 % 16];

   always @(posedge clk) begin
      if (if0.fifo_rd_o) begin
         rp0  <= rp0 + 1;
         pop0 <= pop0 + 1;
      end
      if (if1.fifo_rd_o) rp1 <= rp1 + 1;
      if (if2.fifo_rd_o) rp2 <= rp2 + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push0(input logic [7:0] w);
      mem0[wp0 % 16] = w;
      wp0++;
   endtask

   // Check one DUT-A chunk at the current negedge.
   task automatic chunk0(input string tag, input logic [1:0] d, input logic l, input logic rd);
      check_eq({tag, "_valid"}, 32'(if0.out_valid_o), 32'd1);
      check_eq({tag, "_data"},  32'(if0.out_data_o),  32'(d));
      check_eq({tag, "_last"},  32'(if0.out_last_o),  32'(l));
      check_eq({tag, "_rd"},    32'(if0.fifo_rd_o),   32'(rd));
   endtask

   logic [1:0] exp_two [8];
   logic [1:0] exp_b4  [4];
   logic [1:0] exp_1e  [4];
   logic [1:0] exp_msb [4];
   logic [7:0] exp_n1  [3];
   int unsigned pop_ref;

   initial begin
      exp_two = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b00};
      exp_b4  = '{2'b00, 2'b01, 2'b11, 2'b10};
      exp_1e  = '{2'b10, 2'b11, 2'b01, 2'b00};
      exp_msb = '{2'b10, 2'b11, 2'b01, 2'b00};
      exp_n1  = '{8'h11, 8'h22, 8'h33};
      n_checks = 0;
      n_fail   = 0;
      wp0 = 0; wp1 = 0; wp2 = 0;
      rp0 = 0; rp1 = 0; rp2 = 0;
      pop0 = 0;
      reset = 1'b1;
      if0.out_ready_i = 1'b1; if0.flush_i = 1'b0;
      if1.out_ready_i = 1'b1; if1.flush_i = 1'b0;
      if2.out_ready_i = 1'b1; if2.flush_i = 1'b0;

      repeat (2) @(negedge clk);
      check_eq("rst_valid", 32'(if0.out_valid_o), 32'd0);
      check_eq("rst_last",  32'(if0.out_last_o),  32'd0);
      check_eq("rst_busy",  32'(if0.busy_o),      32'd0);
      check_eq("rst_data",  32'(if0.out_data_o),  32'd0);
      check_eq("rst_rd",    32'(if0.fifo_rd_o),   32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single word, ready held high
      pop_ref = pop0;
      push0(8'hB4);
      #1 check_eq("w1_rd0", 32'(if0.fifo_rd_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chunk0("w1", exp_b4[i], i == 3, 1'b0);
      end
      @(negedge clk);
      check_eq("w1_idle", 32'(if0.out_valid_o), 32'd0);
      check_eq("w1_pops", pop0 - pop_ref, 32'd1);

      // Two words back-to-back
      push0(8'hB4);
      push0(8'h1E);
      #1 check_eq("w2_rd0", 32'(if0.fifo_rd_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chunk0("w2", exp_two[i], (i == 3) || (i == 7), i == 3);
      end
      @(negedge clk);
      check_eq("w2_idle", 32'(if0.out_valid_o), 32'd0);

      // Backpressure after the second chunk
      push0(8'hB4);
      @(negedge clk);
      chunk0("bp0", 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      chunk0("bp1", 2'b01, 1'b0, 1'b0);
      if0.out_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chunk0("bp_hold", 2'b01, 1'b0, 1'b0);
      end
      if0.out_ready_i = 1'b1;
      @(negedge clk);
      chunk0("bp2", 2'b11, 1'b0, 1'b0);
      @(negedge clk);
      chunk0("bp3", 2'b10, 1'b1, 1'b0);
      @(negedge clk);
      check_eq("bp_idle", 32'(if0.out_valid_o), 32'd0);

      // Flush during the second chunk with a word queued behind
      push0(8'hB4);
      push0(8'h1E);
      @(negedge clk);
      chunk0("fl0", 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      chunk0("fl1", 2'b01, 1'b0, 1'b0);
      if0.flush_i = 1'b1;
      #1 check_eq("fl_norid", 32'(if0.fifo_rd_o), 32'd0);
      @(negedge clk);
      if0.flush_i = 1'b0;
      check_eq("fl_valid", 32'(if0.out_valid_o), 32'd0);
      #1 check_eq("fl_reload", 32'(if0.fifo_rd_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chunk0("fl_1e", exp_1e[i], i == 3, 1'b0);
      end
      @(negedge clk);
      check_eq("fl_idle", 32'(if0.out_valid_o), 32'd0);

      // Asynchronous reset mid-word
      push0(8'hB4);
      @(negedge clk);
      chunk0("ar0", 2'b00, 1'b0, 1'b0);
      pop_ref = pop0;
      #2 reset = 1'b1;
      push0(8'h1E);
      #1;
      check_eq("ar_valid", 32'(if0.out_valid_o), 32'd0);
      check_eq("ar_data",  32'(if0.out_data_o),  32'd0);
      check_eq("ar_busy",  32'(if0.busy_o),      32'd0);
      check_eq("ar_rd",    32'(if0.fifo_rd_o),   32'd0);
      wp0--;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("ar_post_valid", 32'(if0.out_valid_o), 32'd0);
         check_eq("ar_post_rd",    32'(if0.fifo_rd_o),   32'd0);
      end
      check_eq("ar_pops", pop0 - pop_ref, 32'd0);

      // MSB-first
      mem1[wp1 % 16] = 8'hB4;
      wp1++;
      #1 check_eq("msb_rd", 32'(if1.fifo_rd_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("msb_valid", 32'(if1.out_valid_o), 32'd1);
         check_eq("msb_data",  32'(if1.out_data_o),  32'(exp_msb[i]));
         check_eq("msb_last",  32'(if1.out_last_o),  32'(i == 3));
      end
      @(negedge clk);
      check_eq("msb_idle", 32'(if1.out_valid_o), 32'd0);

      // N=1: one word per cycle
      for (int i = 0; i < 3; i++) begin
         mem2[wp2 % 16] = exp_n1[i];
         wp2++;
      end
      #1 check_eq("n1_rd0", 32'(if2.fifo_rd_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("n1_valid", 32'(if2.out_valid_o), 32'd1);
         check_eq("n1_data",  32'(if2.out_data_o),  32'(exp_n1[i]));
         check_eq("n1_last",  32'(if2.out_last_o),  32'd1);
         check_eq("n1_rd",    32'(if2.fifo_rd_o),   32'(i < 2));
      end
      @(negedge clk);
      check_eq("n1_idle", 32'(if2.out_valid_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_rd_ser.md
Name: fifo_rd_ser

Overview:
Drain stage that sits directly downstream of the synchronous fifo. It pops DATA_W-bit words from the fifo's show-ahead read port and serialises each word into DATA_W/OUT_W chunks on a valid/ready stream. Words stream back-to-back with no bubble between them while the fifo is non-empty and the sink is ready.

Parameters:
DATA_W, 8, fifo word width; must be a multiple of OUT_W, otherwise elaboration fails.
OUT_W, 2, output chunk width. N = DATA_W/OUT_W chunks per word; N=1 is legal (registered pass-through).
LSB_FIRST, 1, 1 = chunk from bits [OUT_W-1:0] sent first; 0 = MSB chunk first.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
fifo_empty_i  in  1  fifo empty flag
fifo_data_i  in  DATA_W  fifo head word, valid combinationally whenever fifo_empty_i=0
fifo_rd_o  out  1  pop strobe to the fifo; the head word is consumed on this clock edge
flush_i  in  1  synchronous drop of the word in progress
out_valid_o  out  1  chunk valid
out_ready_i  in  1  sink ready
out_data_o  out  OUT_W  current chunk
out_last_o  out  1  current chunk is the final chunk of its word
busy_o  out  1  a word is held (equals out_valid_o)

Behaviour:
- Registered state:
  - shift register sh_q[DATA_W]
  - chunk counter cnt_q, width clog2(N)+1, counts remaining chunks minus 1
  - state: EMPTY or SEND
- Reset (asynchronous, reset=1):
  - state=EMPTY, cnt_q=0, sh_q=0
  - out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0
  - fifo_rd_o is forced to 0 while reset=1
- Outputs:
  - out_data_o = low chunk of sh_q if LSB_FIRST=1, else high chunk.
  - out_valid_o = (state==SEND).
  - out_last_o = out_valid_o & (cnt_q==0).
  - All outputs are registered except fifo_rd_o.
- Load condition (combinational): load = ~fifo_empty_i & ~flush_i & (state==EMPTY | (out_ready_i & out_last_o)).
  - fifo_rd_o = load.
  - On a load edge: sh_q <= fifo_data_i, cnt_q <= N-1, state <= SEND.
  - fifo_rd_o is never 1 while fifo_empty_i=1.
- EMPTY:
  - With ~fifo_empty_i, load the word. out_valid_o rises on the next cycle, giving a latency of 1 cycle from non-empty to first chunk.
  - Otherwise stay in EMPTY.
- SEND, out_ready_i=0: hold. sh_q, cnt_q and out_data_o stay stable; valid is never retracted.
- SEND, out_ready_i=1, cnt_q!=0: shift sh_q by OUT_W (right if LSB_FIRST=1, else left, zero fill) and decrement cnt_q.
- SEND, out_ready_i=1, cnt_q==0:
  - If load, reload in the same cycle (no bubble).
  - Otherwise go to EMPTY.
- flush_i=1 (any state):
  - Next state is EMPTY and cnt_q=0.
  - No pop that cycle.
  - flush_i has priority over ready and load.
  - Words still in the fifo are unaffected.
- Throughput: one chunk per cycle while ready. Sustained word rate is 1 per N cycles.
- Reset mid-word:
  - The partial word is discarded and no further chunks are emitted.
  - The fifo's own pointer state is the fifo's responsibility.
- N=1:
  - cnt_q is always 0 and out_last_o=out_valid_o.
  - The stage behaves as a one-entry registered stage popping every cycle while ready and non-empty.

Test Plan:
- DATA_W=8, OUT_W=2, LSB_FIRST=1; push 0xB4, ready held 1.
  - -> fifo_rd_o pulses once.
  - -> out_data_o = 00, 01, 11, 10 on consecutive cycles after 1 cycle of latency.
  - -> out_last_o=1 only on the 10 chunk.
  - -> out_valid_o then drops.
- Two words 0xB4, 0x1E already in the fifo, ready=1.
  - -> 8 consecutive valid chunks: 00,01,11,10,10,11,01,00.
  - -> second fifo_rd_o is coincident with the first word's last chunk (no gap).
- Backpressure: ready=0 for 3 cycles after the second chunk of 0xB4.
  - -> out_data_o holds 01 and out_valid_o stays 1 throughout.
  - -> the sequence resumes 11,10 when ready returns.
- flush_i pulsed during the second chunk of 0xB4 while 0x1E is queued.
  - -> next cycle out_valid_o=0.
  - -> the following cycle 0x1E loads, and its chunks 10,11,01,00 are emitted.
- Async reset asserted mid-word, between clock edges.
  - -> out_valid_o=0 immediately and fifo_rd_o=0 while reset=1.
  - -> after release with the fifo empty: no output and no pop.
- LSB_FIRST=0 and 0xB4 -> chunks 10,11,01,00. Then N=1 (OUT_W=8) with ready=1 and 3 words -> one word per cycle.
